// File: rtl/io_controller.sv
// Switch/LED I/O controller: two-flop synchroniser and per-bit debounce on switch pins,
// sticky CPU-acknowledged rise flags, and a CPU-written LED register with shared blink phase.
module io_controller #(
    parameter int WIDTH             = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_PERIOD = 50_000_000
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_rise,
    input  logic [WIDTH-1:0] ack,
    input  logic [WIDTH-1:0] led_data,
    input  logic             led_we,
    input  logic [WIDTH-1:0] blink_en,
    output logic [WIDTH-1:0] led
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_PERIOD - 1);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            switch_q, switch_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            led_q, led_d;
    logic [WIDTH-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [BLK_W-1:0]            blk_cnt_q, blk_cnt_d;
    logic                        phase_q, phase_d;

    // A bit's counter only advances while the synchronised level disagrees with the
    // accepted level; any agreement restarts it, so short glitches never land.
    always_comb begin
        switch_d = switch_q;
        for (int i = 0; i < WIDTH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != switch_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    switch_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Set beats ack when both land on the same edge.
    always_comb begin
        rise_d = (rise_q & ~ack) | (switch_d & ~switch_q);
        led_d  = led_we ? led_data : led_q;
    end

    always_comb begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            switch_q  <= '0;
            rise_q    <= '0;
            led_q     <= '0;
            db_cnt_q  <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            sync1_q   <= switch_raw;
            sync2_q   <= sync1_q;
            switch_q  <= switch_d;
            rise_q    <= rise_d;
            led_q     <= led_d;
            db_cnt_q  <= db_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign switch      = switch_q;
    assign switch_rise = rise_q;
    assign led         = led_q & (~blink_en | {WIDTH{phase_q}});

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: directed steps plus random traffic compared each cycle
// against a sample-history reference model.
module tb_io_controller;
    localparam int W   = 4;
    localparam int DC  = 4;
    localparam int BHP = 8;

    logic         clk;
    logic         n_reset;
    logic [W-1:0] switch_raw, switch, switch_rise, ack, led_data, blink_en, led;
    logic         led_we;

    int checks = 0;
    int errors = 0;

    io_controller #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .BLINK_HALF_PERIOD(BHP)) dut (
        .clk(clk), .n_reset(n_reset), .switch_raw(switch_raw), .switch(switch),
        .switch_rise(switch_rise), .ack(ack), .led_data(led_data), .led_we(led_we),
        .blink_en(blink_en), .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a level is accepted once the last DC synchronised samples
    // (raw samples delayed two edges) all show the opposite of the current level.
    logic [W-1:0] hist [0:DC+1];
    logic [W-1:0] m_sw, m_rise, m_reg, m_led, nsw;
    int           m_edges;
    logic         m_phase;

    always_comb begin
        nsw = m_sw;
        for (int b = 0; b < W; b++) begin
            logic ok;
            ok = 1'b1;
            for (int j = 1; j <= DC; j++)
                if (hist[j][b] == m_sw[b]) ok = 1'b0;
            if (ok) nsw[b] = ~m_sw[b];
        end
    end

    assign m_phase = ((m_edges / BHP) % 2) == 1;
    assign m_led   = m_reg & (~blink_en | {W{m_phase}});

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int j = 0; j <= DC + 1; j++) hist[j] <= '0;
            m_sw    <= '0;
            m_rise  <= '0;
            m_reg   <= '0;
            m_edges <= 0;
        end else begin
            for (int j = 0; j < DC + 1; j++) hist[j] <= hist[j+1];
            hist[DC+1] <= switch_raw;
            m_sw       <= nsw;
            m_rise     <= (m_rise & ~ack) | (nsw & ~m_sw);
            if (led_we) m_reg <= led_data;
            m_edges    <= m_edges + 1;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check("model_switch", switch, m_sw);
        check("model_rise", switch_rise, m_rise);
        check("model_led", led, m_led);
    endtask

    initial begin
        n_reset    = 1'b0;
        switch_raw = 4'b1111;
        led_we     = 1'b1;
        led_data   = 4'b1111;
        blink_en   = 4'b0000;
        ack        = 4'b0000;

        // 1: reset values with active inputs
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("rst_switch", switch, 4'b0000);
            check("rst_rise", switch_rise, 4'b0000);
            check("rst_led", led, 4'b0000);
        end

        // 5: LED blink right after release
        n_reset    = 1'b1;
        switch_raw = 4'b0000;
        led_data   = 4'b1010;
        blink_en   = 4'b1000;
        for (int e = 1; e <= 24; e++) begin
            cyc();
            led_we = 1'b0;
            check("blink_led", led, (((e / BHP) % 2) == 1) ? 4'b1010 : 4'b0010);
        end
        blink_en = 4'b0000;
        for (int n = 0; n < 10; n++) begin
            cyc();
            check("steady_led", led, 4'b1010);
        end

        // 2: clean press then release
        switch_raw = 4'b0001;
        for (int n = 0; n <= 5; n++) begin
            cyc();
            check("press_switch", switch, (n == 5) ? 4'b0001 : 4'b0000);
            check("press_rise", switch_rise, (n == 5) ? 4'b0001 : 4'b0000);
        end
        switch_raw = 4'b0000;
        for (int n = 0; n <= 5; n++) begin
            cyc();
            check("release_switch", switch, (n == 5) ? 4'b0000 : 4'b0001);
            check("release_rise", switch_rise, 4'b0001);
        end
        ack = 4'b0001;
        cyc();
        ack = 4'b0000;
        check("ack_clear", switch_rise, 4'b0000);

        // 3: glitch rejection, then an accepted 6-cycle pulse
        switch_raw = 4'b0010;
        repeat (3) cyc();
        switch_raw = 4'b0000;
        for (int n = 0; n < 10; n++) begin
            cyc();
            check("glitch_switch", switch, 4'b0000);
            check("glitch_rise", switch_rise, 4'b0000);
        end
        switch_raw = 4'b0010;
        repeat (6) cyc();
        switch_raw = 4'b0000;
        repeat (12) cyc();
        check("pulse6_rise", switch_rise, 4'b0010);
        check("pulse6_switch", switch, 4'b0000);
        ack = 4'b0010;
        cyc();
        ack = 4'b0000;

        // 4: ack on the same edge as the rise
        switch_raw = 4'b0001;
        repeat (5) cyc();
        ack = 4'b0001;
        cyc();
        check("race_switch", switch, 4'b0001);
        check("race_rise", switch_rise, 4'b0001);
        cyc();
        ack = 4'b0000;
        check("race_ack_clear", switch_rise, 4'b0000);
        switch_raw = 4'b0000;
        repeat (8) cyc();

        // 6: async reset mid-debounce with a pending flag
        switch_raw = 4'b0100;
        repeat (6) cyc();
        check("pre_rst_rise", switch_rise, 4'b0100);
        switch_raw = 4'b0000;
        repeat (4) cyc();
        #($urandom_range(1, 3));
        n_reset    = 1'b0;
        switch_raw = 4'b0100;
        #1;
        check("async_switch", switch, 4'b0000);
        check("async_rise", switch_rise, 4'b0000);
        check("async_led", led, 4'b0000);
        repeat (2) cyc();
        n_reset = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            cyc();
            check("rerun_switch", switch, (n == 5) ? 4'b0100 : 4'b0000);
        end

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #($urandom_range(1, 4));
                n_reset = 1'b0;
                #1;
                check("rand_rst_switch", switch, 4'b0000);
                check("rand_rst_led", led, 4'b0000);
                @(negedge clk);
                n_reset = 1'b1;
            end
            cyc();
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) switch_raw[b] = ~switch_raw[b];
            ack      = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            led_we   = ($urandom_range(0, 4) == 0);
            led_data = W'($urandom);
            if ($urandom_range(0, 19) == 0) blink_en = W'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
